// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS       = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 10418;
    localparam int unsigned BIT_TIMER_W          = 16;
    localparam int unsigned BIT_IDX_W            = $clog2(UART_DATA_BITS);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Core-side byte handshake plus the serial line and status of the transmitter.
interface uart_tx_ctrl_if;
    import uart_pkg::*;

    logic                      tx_start;
    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      tx_ready;
    logic                      tx_busy;
    logic                      tx_done;
    logic                      tx_serial;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_ready,
        input  tx_busy,
        input  tx_done,
        input  tx_serial
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_ready,
        output tx_busy,
        output tx_done,
        output tx_serial
    );

endinterface

// File: rtl/baud_tick_gen.sv
// Bit-time counter: bit_end marks the last clk_in cycle of each serial bit.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic bit_end
);

    localparam logic [BIT_TIMER_W-1:0] LAST_CNT = BIT_TIMER_W'(CLKS_PER_BIT - 1);

    logic [BIT_TIMER_W-1:0] cnt_q, cnt_d;

    assign bit_end = en && (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || bit_end) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// 8N1 transmit sequencer with a one-byte holding register ahead of the shift register.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic           clk_in,
    input  logic           rst_n,
    uart_tx_ctrl_if.slave  bus
);

    localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(UART_DATA_BITS - 1);

    tx_state_t                 state_q, state_d;
    logic                      hold_full_q, hold_full_d;
    logic [UART_DATA_BITS-1:0] hold_q, hold_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic                      serial_q, serial_d;
    logic                      done_q, done_d;
    logic                      bit_end;
    logic                      timer_clr;
    logic                      timer_en;
    logic                      accept;
    logic                      load;

    // Timer restarts on every state change and idles at zero in IDLE.
    assign timer_clr = (state_d != state_q);
    assign timer_en  = (state_q != IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick_gen (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hold_full_q) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && (bit_idx_q == LAST_IDX)) state_d = STOP;
            STOP:    if (bit_end) state_d = hold_full_q ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept      = bus.tx_start && !hold_full_q;
        // Holding byte moves to the shift register when a frame begins.
        load        = hold_full_q && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        serial_d    = 1'b1;
        done_d      = 1'b0;

        if (accept) begin
            hold_full_d = 1'b1;
            hold_d      = bus.tx_data;
        end else if (load) begin
            hold_full_d = 1'b0;
        end

        if (load) begin
            shift_d = hold_q;
        end

        case (state_q)
            IDLE: begin
                bit_idx_d = '0;
            end
            START: begin
                serial_d = 1'b0;
            end
            DATA: begin
                serial_d = shift_q[0];
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            STOP: begin
                serial_d = 1'b1;
                done_d   = bit_end;
            end
            default: begin
                serial_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            serial_q    <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            serial_q    <= serial_d;
            done_q      <= done_d;
        end
    end

    assign bus.tx_ready  = !hold_full_q;
    assign bus.tx_busy   = (state_q != IDLE) || hold_full_q;
    assign bus.tx_done   = done_q;
    assign bus.tx_serial = serial_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a line monitor decodes frames against a queue of accepted bytes.
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    localparam int CPB   = 16;
    localparam int CPB4  = 4;
    localparam int FRAME = 10 * CPB;

    logic clk_in = 1'b0;
    logic rst_n;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    uart_tx_ctrl_if bus16();
    uart_tx_ctrl_if bus4();

    uart_tx_ctrl #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus16)
    );

    uart_tx_ctrl #(
        .CLKS_PER_BIT (CPB4)
    ) dut4 (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus4)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, want finish", cyc);
        $fatal(1, "watchdog");
    end

    // Scoreboard and line monitor for the CPB=16 instance.
    logic [7:0] exp_q[$];
    logic [7:0] exp4_q[$];
    int         frame_start[$];
    int         done_cyc[$];
    logic       busy_log[int];
    int         frames   = 0;
    int         done_cnt = 0;
    int         mon_cnt  = 0;
    bit         in_frame = 1'b0;
    bit         bit_bad  = 1'b0;
    logic       bad_lvl;
    logic [9:0] exp_pat;
    logic [3:0] bidx;
    logic [7:0] mon_byte;

    always @(negedge clk_in) begin
        busy_log[cyc] = bus16.tx_busy;
        if (bus16.tx_done === 1'b1) begin
            done_cnt++;
            done_cyc.push_back(cyc);
        end
        if (rst_n !== 1'b1) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && bus16.tx_serial === 1'b0) begin
                in_frame = 1'b1;
                mon_cnt  = 0;
                bit_bad  = 1'b0;
                frame_start.push_back(cyc);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_frame: frame starts at cycle %0d, want no frame",
                             cyc);
                    exp_pat = 10'h3fe;
                end else begin
                    mon_byte = exp_q.pop_front();
                    exp_pat  = {1'b1, mon_byte, 1'b0};
                end
            end
            if (in_frame) begin
                bidx = 4'(mon_cnt / CPB);
                if (bus16.tx_serial !== exp_pat[bidx]) begin
                    bit_bad = 1'b1;
                    bad_lvl = bus16.tx_serial;
                end
                mon_cnt++;
                if (mon_cnt % CPB == 0) begin
                    total++;
                    if (bit_bad) begin
                        bad++;
                        $display("FAIL frame_bit%0d: line got %b, want %b for all %0d cycles",
                                 bidx, bad_lvl, exp_pat[bidx], CPB);
                    end
                    bit_bad = 1'b0;
                    if (mon_cnt == FRAME) begin
                        in_frame = 1'b0;
                        frames++;
                    end
                end
            end
        end
    end

    task automatic send16(input logic [7:0] d, output int k);
        int waited = 0;
        @(negedge clk_in);
        while (bus16.tx_ready !== 1'b1 && waited < 4 * FRAME) begin
            @(negedge clk_in);
            waited++;
        end
        total++;
        if (bus16.tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_ready: tx_ready got %b, want 1", bus16.tx_ready);
        end
        bus16.tx_start = 1'b1;
        bus16.tx_data  = d;
        exp_q.push_back(d);
        @(negedge clk_in);
        bus16.tx_start = 1'b0;
        k = cyc;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames < target && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        total++;
        if (frames < target) begin
            bad++;
            $display("FAIL frame_count: got %0d frames, want %0d", frames, target);
        end
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk_in);
    endtask

    task automatic test_reset;
        int e_ser = 0;
        int e_rdy = 0;
        int e_busy = 0;
        int e_done = 0;
        rst_n          = 1'b0;
        bus16.tx_start = 1'b0;
        bus16.tx_data  = 8'h00;
        bus4.tx_start  = 1'b0;
        bus4.tx_data   = 8'h00;
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (200) begin
            @(negedge clk_in);
            if (bus16.tx_serial !== 1'b1 || bus4.tx_serial !== 1'b1) e_ser++;
            if (bus16.tx_ready !== 1'b1 || bus4.tx_ready !== 1'b1) e_rdy++;
            if (bus16.tx_busy !== 1'b0 || bus4.tx_busy !== 1'b0) e_busy++;
            if (bus16.tx_done !== 1'b0 || bus4.tx_done !== 1'b0) e_done++;
        end
        total++;
        if (e_ser !== 0) begin bad++; $display("FAIL idle_serial: %0d bad cycles, want 0", e_ser); end
        total++;
        if (e_rdy !== 0) begin bad++; $display("FAIL idle_ready: %0d bad cycles, want 0", e_rdy); end
        total++;
        if (e_busy !== 0) begin bad++; $display("FAIL idle_busy: %0d bad cycles, want 0", e_busy); end
        total++;
        if (e_done !== 0) begin bad++; $display("FAIL idle_done: %0d bad cycles, want 0", e_done); end
    endtask

    task automatic test_single;
        int k, fs0, d0, s0, t;
        fs0 = frame_start.size();
        d0  = done_cnt;
        send16(8'hA5, k);
        wait_frames(frames + 1, FRAME + 20);
        repeat (4) @(negedge clk_in);
        s0 = (frame_start.size() > fs0) ? frame_start[fs0] : -1;
        total++;
        if (s0 !== k + 2) begin
            bad++;
            $display("FAIL single_start_latency: line low at cycle %0d, want %0d", s0, k + 2);
        end
        total++;
        if (done_cnt - d0 !== 1) begin
            bad++;
            $display("FAIL single_done_count: got %0d pulses, want 1", done_cnt - d0);
        end
        t = (done_cyc.size() > d0) ? done_cyc[d0] : -1;
        total++;
        if (t !== k + 1 + FRAME) begin
            bad++;
            $display("FAIL single_done_timing: pulse at cycle %0d, want %0d", t, k + 1 + FRAME);
        end
    endtask

    task automatic test_back_to_back;
        int k1, k2, fs0, d0, s0, s1, t0, t1, lows;
        fs0 = frame_start.size();
        d0  = done_cnt;
        send16(8'h00, k1);
        send16(8'hFF, k2);
        wait_frames(frames + 2, 2 * FRAME + 40);
        repeat (4) @(negedge clk_in);
        s0 = (frame_start.size() > fs0) ? frame_start[fs0] : -1;
        s1 = (frame_start.size() > fs0 + 1) ? frame_start[fs0 + 1] : -1;
        total++;
        if (s1 - s0 !== FRAME) begin
            bad++;
            $display("FAIL b2b_gap: second start %0d cycles after first, want %0d", s1 - s0, FRAME);
        end
        total++;
        if (done_cnt - d0 !== 2) begin
            bad++;
            $display("FAIL b2b_done_count: got %0d pulses, want 2", done_cnt - d0);
        end
        t0 = (done_cyc.size() > d0) ? done_cyc[d0] : -1;
        t1 = (done_cyc.size() > d0 + 1) ? done_cyc[d0 + 1] : -1;
        total++;
        if (t0 !== k1 + 1 + FRAME || t1 !== k1 + 1 + 2 * FRAME) begin
            bad++;
            $display("FAIL b2b_done_timing: pulses at %0d,%0d, want %0d,%0d",
                     t0, t1, k1 + 1 + FRAME, k1 + 1 + 2 * FRAME);
        end
        lows = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (busy_log[k1 + 1 + i] !== 1'b1) lows++;
        end
        total++;
        if (lows !== 0) begin
            bad++;
            $display("FAIL b2b_busy_hold: busy low on %0d of %0d cycles, want 0", lows, 2 * FRAME);
        end
        total++;
        if (busy_log[k1 + 1 + 2 * FRAME] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_busy_release: busy got %b after stream, want 0",
                     busy_log[k1 + 1 + 2 * FRAME]);
        end
    endtask

    task automatic test_overrun;
        int k, f0, fs0;
        f0  = frames;
        fs0 = frame_start.size();
        send16(8'h55, k);
        total++;
        if (bus16.tx_ready !== 1'b0) begin
            bad++;
            $display("FAIL overrun_ready: tx_ready got %b while holding, want 0", bus16.tx_ready);
        end
        bus16.tx_start = 1'b1;
        bus16.tx_data  = 8'h3C;
        @(negedge clk_in);
        bus16.tx_start = 1'b0;
        wait_frames(f0 + 1, FRAME + 20);
        repeat (3 * FRAME) @(negedge clk_in);
        total++;
        if (frame_start.size() - fs0 !== 1) begin
            bad++;
            $display("FAIL overrun_frames: got %0d frames, want 1", frame_start.size() - fs0);
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL overrun_queue: %0d bytes never sent, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        int k, e, d0, f0;
        d0 = done_cnt;
        f0 = frames;
        send16(8'h81, k);
        e = k + 1;
        wait_to(e + 5 * CPB + 3);
        total++;
        if (bus16.tx_serial !== 1'b0) begin
            bad++;
            $display("FAIL mid_bit4_level: line got %b in data bit 4, want 0", bus16.tx_serial);
        end
        rst_n = 1'b0;
        @(negedge clk_in);
        total++;
        if (bus16.tx_serial !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_line: line got %b after reset edge, want 1", bus16.tx_serial);
        end
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        total++;
        if (bus16.tx_ready !== 1'b1 || bus16.tx_busy !== 1'b0 || bus16.tx_serial !== 1'b1) begin
            bad++;
            $display("FAIL mid_after_release: ready/busy/line got %b%b%b, want 101",
                     bus16.tx_ready, bus16.tx_busy, bus16.tx_serial);
        end
        repeat (2 * FRAME) @(negedge clk_in);
        total++;
        if (done_cnt !== d0 || frames !== f0) begin
            bad++;
            $display("FAIL mid_no_done: done pulses %0d frames %0d, want 0 and 0",
                     done_cnt - d0, frames - f0);
        end
    endtask

    task automatic test_extreme;
        int k, s, n, dones, done_at;
        logic [7:0] b;
        logic [9:0] pat;
        bit   bit_err;
        logic busy_pre, busy_end;
        @(negedge clk_in);
        bus4.tx_start = 1'b1;
        bus4.tx_data  = 8'h01;
        exp4_q.push_back(8'h01);
        @(negedge clk_in);
        bus4.tx_start = 1'b0;
        k = cyc;
        n = 0;
        while (bus4.tx_serial !== 1'b0 && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        s = cyc;
        total++;
        if (s !== k + 2) begin
            bad++;
            $display("FAIL x_start_latency: line low at cycle %0d, want %0d", s, k + 2);
        end
        b       = exp4_q.pop_front();
        pat     = {1'b1, b, 1'b0};
        dones   = 0;
        done_at = -1;
        busy_pre = 1'b0;
        busy_end = 1'b1;
        for (int j = 0; j < 10; j++) begin
            bit_err = 1'b0;
            for (int i = 0; i < CPB4; i++) begin
                if (bus4.tx_serial !== pat[4'(j)]) bit_err = 1'b1;
                if (bus4.tx_done === 1'b1) begin
                    dones++;
                    done_at = cyc;
                end
                if (j == 9 && i == CPB4 - 2) busy_pre = bus4.tx_busy;
                if (j == 9 && i == CPB4 - 1) busy_end = bus4.tx_busy;
                @(negedge clk_in);
            end
            total++;
            if (bit_err) begin
                bad++;
                $display("FAIL x_bit%0d: level not %b for all %0d cycles", j, pat[4'(j)], CPB4);
            end
        end
        repeat (8) begin
            if (bus4.tx_done === 1'b1) dones++;
            if (bus4.tx_serial !== 1'b1) bit_err = 1'b1;
            @(negedge clk_in);
        end
        total++;
        if (dones !== 1 || done_at !== s + 10 * CPB4 - 1) begin
            bad++;
            $display("FAIL x_done: %0d pulses at cycle %0d, want 1 at %0d",
                     dones, done_at, s + 10 * CPB4 - 1);
        end
        total++;
        if (busy_pre !== 1'b1 || busy_end !== 1'b0) begin
            bad++;
            $display("FAIL x_frame_len: busy at end of frame got %b%b, want 10", busy_pre, busy_end);
        end
        total++;
        if (bit_err) begin
            bad++;
            $display("FAIL x_line_after: line left high got 0, want 1");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_extreme();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL final_queue: %0d bytes pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
